mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - master-side and adapter-side signal bundle for mem_arbiter
//
// Purpose: groups the two master ports and the downstream adapter port.
// Modports:
//   slave  - arbiter view: consumes i_* signals, drives o_* signals
//   master - driver view (masters + adapter model): drives i_*, observes o_*
// Signals:
//   i_m0_*/i_m1_*  master address, write data, req, we, next
//   o_m0_*/o_m1_*  read data (broadcast) and owner-only ack
//   o_mem_*        address, write data, req, we, next towards the adapter
//   i_mem_*        read data and ack from the adapter
//   o_timeout      one-cycle pulse on watchdog release
//   o_owner        debug owner code: 00 idle, 01 m0, 10 m1
interface mem_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] i_m0_addr, i_m1_addr;
  logic [DATA_W-1:0] i_m0_data, i_m1_data;
  logic              i_m0_req, i_m1_req;
  logic              i_m0_we, i_m1_we;
  logic              i_m0_next, i_m1_next;
  logic [DATA_W-1:0] o_m0_data, o_m1_data;
  logic              o_m0_ack, o_m1_ack;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_data;
  logic              o_mem_req, o_mem_we, o_mem_next;
  logic [DATA_W-1:0] i_mem_data;
  logic              i_mem_ack;
  logic              o_timeout;
  logic [1:0]        o_owner;

  modport slave (
    input  i_m0_addr, i_m1_addr, i_m0_data, i_m1_data,
    input  i_m0_req, i_m1_req, i_m0_we, i_m1_we, i_m0_next, i_m1_next,
    input  i_mem_data, i_mem_ack,
    output o_m0_data, o_m1_data, o_m0_ack, o_m1_ack,
    output o_mem_addr, o_mem_data, o_mem_req, o_mem_we, o_mem_next,
    output o_timeout, o_owner
  );

  modport master (
    output i_m0_addr, i_m1_addr, i_m0_data, i_m1_data,
    output i_m0_req, i_m1_req, i_m0_we, i_m1_we, i_m0_next, i_m1_next,
    output i_mem_data, i_mem_ack,
    input  o_m0_data, o_m1_data, o_m0_ack, o_m1_ack,
    input  o_mem_addr, o_mem_data, o_mem_req, o_mem_we, o_mem_next,
    input  o_timeout, o_owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter for the memory adapter port
//
// Purpose: shares one downstream memory port between the instruction-fetch
// unit (m0) and the load/store unit (m1). Round-robin on ties, grant held
// across next-bursts, ack routed to the owner only, watchdog release on a
// transfer that never acks.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      mem_arbiter_if.slave (master ports, adapter port, debug)
module mem_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic          i_clk,
  input logic          i_rst_n,
  mem_arbiter_if.slave bus
);

  // Watchdog fires in the TIMEOUT-th consecutive cycle without ack, i.e.
  // when the registered count already holds TIMEOUT-1.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  localparam bit         WD_EN   = (TIMEOUT != 0);

  // Encoding doubles as the o_owner debug code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic       last, last_nxt;   // 0: m0 granted most recently, 1: m1
  logic [7:0] cnt, cnt_nxt;
  logic       wd_fire;

  logic              owned, sel1;
  logic              x_req, x_next, x_we, y_req;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // Owner-relative view: x is the current owner, y the other master.
  assign owned     = (state != IDLE);
  assign sel1      = (state == OWN1);
  assign x_req     = sel1 ? bus.i_m1_req  : bus.i_m0_req;
  assign x_next    = sel1 ? bus.i_m1_next : bus.i_m0_next;
  assign x_we      = sel1 ? bus.i_m1_we   : bus.i_m0_we;
  assign y_req     = sel1 ? bus.i_m0_req  : bus.i_m1_req;
  assign addr_sel  = sel1 ? bus.i_m1_addr : bus.i_m0_addr;
  assign wdata_sel = sel1 ? bus.i_m1_data : bus.i_m0_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter defaults to clear: it only survives a cycle spent owning
  // without ack, so entering OWNx, any ack and IDLE all restart it.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = 8'd0;
    wd_fire   = 1'b0;
    if (!owned) begin
      if (bus.i_m0_req && (!bus.i_m1_req || last)) begin
        state_nxt = OWN0;
        last_nxt  = 1'b0;
      end else if (bus.i_m1_req) begin
        state_nxt = OWN1;
        last_nxt  = 1'b1;
      end
    end else if (bus.i_mem_ack) begin
      if (!x_next) begin
        // End of transaction: a waiting master beats the owner's re-request.
        if (y_req) begin
          state_nxt = sel1 ? OWN0 : OWN1;
          last_nxt  = !sel1;
        end else if (!x_req) begin
          state_nxt = IDLE;
        end
      end
    end else if (!x_req) begin
      state_nxt = IDLE;
    end else if (WD_EN && (cnt == WD_LAST)) begin
      wd_fire   = 1'b1;
      state_nxt = IDLE;
      last_nxt  = sel1;
    end else begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  // Downstream control is gated by ownership, so IDLE never passes a raw
  // request through; address/data simply follow m0 while idle.
  assign bus.o_mem_addr = addr_sel;
  assign bus.o_mem_data = wdata_sel;
  assign bus.o_mem_req  = owned & x_req;
  assign bus.o_mem_we   = owned & x_we;
  assign bus.o_mem_next = owned & x_next;

  assign bus.o_m0_ack  = (state == OWN0) & bus.i_mem_ack;
  assign bus.o_m1_ack  = sel1 & bus.i_mem_ack;
  assign bus.o_m0_data = bus.i_mem_data;
  assign bus.o_m1_data = bus.i_mem_data;
  assign bus.o_timeout = wd_fire;
  assign bus.o_owner   = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 i_clk = ~i_clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_m0_addr = '0; bus.i_m1_addr = '0;
    bus.i_m0_data = '0; bus.i_m1_data = '0;
    bus.i_m0_req = 0; bus.i_m1_req = 0;
    bus.i_m0_we = 0; bus.i_m1_we = 0;
    bus.i_m0_next = 0; bus.i_m1_next = 0;
    bus.i_mem_data = '0; bus.i_mem_ack = 0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    bus.i_mem_data = 16'h5555;
    #2;
    // Reset state
    chk("rst_owner", 32'(bus.o_owner), 32'h0);
    chk("rst_req", 32'(bus.o_mem_req), 32'h0);
    chk("rst_timeout", 32'(bus.o_timeout), 32'h0);
    chk("rst_rdata", 32'(bus.o_m0_data), 32'h5555);
    step();
    i_rst_n = 1'b1;

    // Single master, ack two cycles after grant
    bus.i_m0_addr = 24'h000100;
    bus.i_m0_req  = 1;
    #1 chk("s_no_comb_req", 32'(bus.o_mem_req), 32'h0);
    step();
    #1 chk("s_owner", 32'(bus.o_owner), 32'h1);
    chk("s_req", 32'(bus.o_mem_req), 32'h1);
    chk("s_addr", 32'(bus.o_mem_addr), 32'h000100);
    chk("s_ack_wait", 32'(bus.o_m0_ack), 32'h0);
    step();
    step();
    bus.i_mem_ack = 1;
    #1 chk("s_m0_ack", 32'(bus.o_m0_ack), 32'h1);
    chk("s_m1_ack", 32'(bus.o_m1_ack), 32'h0);
    step();
    bus.i_mem_ack = 0;
    bus.i_m0_req  = 0;
    #1 chk("s_ack_once", 32'(bus.o_m0_ack), 32'h0);
    chk("s_req_drop", 32'(bus.o_mem_req), 32'h0);
    step();
    #1 chk("s_idle", 32'(bus.o_owner), 32'h0);

    // Tie and fairness after reset
    do_reset();
    bus.i_m0_addr = 24'h000010;
    bus.i_m1_addr = 24'h000020;
    bus.i_m0_req = 1;
    bus.i_m1_req = 1;
    step();
    #1 chk("t_grant1", 32'(bus.o_owner), 32'h1);
    chk("t_addr1", 32'(bus.o_mem_addr), 32'h000010);
    bus.i_mem_ack = 1;
    step();
    bus.i_mem_ack = 0;
    #1 chk("t_grant2", 32'(bus.o_owner), 32'h2);
    chk("t_addr2", 32'(bus.o_mem_addr), 32'h000020);
    chk("t_m1_noack", 32'(bus.o_m1_ack), 32'h0);
    bus.i_mem_ack = 1;
    #1 chk("t_m1_ack", 32'(bus.o_m1_ack), 32'h1);
    step();
    #1 chk("t_grant3", 32'(bus.o_owner), 32'h1);
    step();
    bus.i_mem_ack = 0;
    #1 chk("t_grant4", 32'(bus.o_owner), 32'h2);
    bus.i_m0_req = 0;
    bus.i_m1_req = 0;
    step();
    #1 chk("t_abort_idle", 32'(bus.o_owner), 32'h0);

    // Burst lock: m1 four-beat burst, m0 waiting
    bus.i_m1_addr = 24'h0000A0;
    bus.i_m1_req  = 1;
    bus.i_m1_next = 1;
    step();
    #1 chk("b_owner", 32'(bus.o_owner), 32'h2);
    chk("b_next", 32'(bus.o_mem_next), 32'h1);
    bus.i_m0_req = 1;
    for (int k = 0; k < 4; k++) begin
      bus.i_m1_addr = 24'h0000A0 + 24'(k);
      bus.i_m1_next = (k < 3);
      bus.i_mem_ack = 1;
      #1 chk("b_locked", 32'(bus.o_owner), 32'h2);
      chk("b_addr", 32'(bus.o_mem_addr), 32'h0000A0 + 32'(k));
      chk("b_m1_ack", 32'(bus.o_m1_ack), 32'h1);
      chk("b_m0_ack", 32'(bus.o_m0_ack), 32'h0);
      step();
    end
    bus.i_mem_ack = 0;
    bus.i_m1_req  = 0;
    bus.i_m1_next = 0;
    #1 chk("b_handoff", 32'(bus.o_owner), 32'h1);
    bus.i_m0_req = 0;
    step();
    #1 chk("b_idle", 32'(bus.o_owner), 32'h0);

    // Write path and broadcast read data
    bus.i_m1_we   = 1;
    bus.i_m1_data = 16'hBEEF;
    bus.i_m1_req  = 1;
    step();
    bus.i_mem_data = 16'h1234;
    #1 chk("w_owner", 32'(bus.o_owner), 32'h2);
    chk("w_we", 32'(bus.o_mem_we), 32'h1);
    chk("w_data", 32'(bus.o_mem_data), 32'hBEEF);
    chk("w_rd_m0", 32'(bus.o_m0_data), 32'h1234);
    chk("w_rd_m1", 32'(bus.o_m1_data), 32'h1234);
    bus.i_mem_ack = 1;
    #1 chk("w_m1_ack", 32'(bus.o_m1_ack), 32'h1);
    chk("w_m0_ack", 32'(bus.o_m0_ack), 32'h0);
    step();
    bus.i_mem_ack = 0;
    bus.i_m1_req  = 0;
    bus.i_m1_we   = 0;
    step();
    bus.i_m0_addr = 24'h123456;
    #1 chk("w_idle", 32'(bus.o_owner), 32'h0);
    chk("w_idle_we", 32'(bus.o_mem_we), 32'h0);
    chk("w_idle_addr", 32'(bus.o_mem_addr), 32'h123456);
    bus.i_mem_ack = 1;
    #1 chk("i_stale_m0", 32'(bus.o_m0_ack), 32'h0);
    chk("i_stale_m1", 32'(bus.o_m1_ack), 32'h0);
    step();
    bus.i_mem_ack = 0;
    #1 chk("i_stale_idle", 32'(bus.o_owner), 32'h0);

    // Watchdog: m0 never acked, m1 pending
    bus.i_m0_req = 1;
    bus.i_m1_req = 1;
    step();
    for (int i = 1; i < 8; i++) begin
      #1 chk("wd_quiet", 32'(bus.o_timeout), 32'h0);
      chk("wd_owner", 32'(bus.o_owner), 32'h1);
      step();
    end
    #1 chk("wd_pulse", 32'(bus.o_timeout), 32'h1);
    chk("wd_no_ack", 32'(bus.o_m0_ack), 32'h0);
    step();
    #1 chk("wd_idle", 32'(bus.o_owner), 32'h0);
    chk("wd_pulse_end", 32'(bus.o_timeout), 32'h0);
    step();
    #1 chk("wd_m1_next", 32'(bus.o_owner), 32'h2);
    bus.i_m0_req = 0;
    bus.i_m1_req = 0;
    step();
    bus.i_mem_ack = 1;
    #1 chk("wd_stale_m0", 32'(bus.o_m0_ack), 32'h0);
    chk("wd_stale_m1", 32'(bus.o_m1_ack), 32'h0);
    step();
    bus.i_mem_ack = 0;
    #1 chk("wd_stay_idle", 32'(bus.o_owner), 32'h0);

    // Asynchronous reset mid-burst
    bus.i_m0_req  = 1;
    bus.i_m0_next = 1;
    step();
    bus.i_mem_ack = 1;
    step();
    bus.i_mem_ack = 0;
    #1 chk("r_busy", 32'(bus.o_mem_req), 32'h1);
    #1 i_rst_n = 1'b0;
    #1 chk("r_req_drop", 32'(bus.o_mem_req), 32'h0);
    chk("r_owner", 32'(bus.o_owner), 32'h0);
    clear_inputs();
    step();
    i_rst_n = 1'b1;
    bus.i_m0_req = 1;
    bus.i_m1_req = 1;
    step();
    #1 chk("r_tie_m0", 32'(bus.o_owner), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
